// File: rtl/fd_pkg.sv
// Shared widths, state encoding and bubble constant for the fetch/decode latch.
package fd_pkg;

  localparam int PC_W_DEF   = 12;
  localparam int INSN_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  localparam logic [INSN_W_DEF-1:0] NOP = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fd_state_t;

endpackage

// File: rtl/fd_latch_if.sv
// Fetch-side inputs and decode-side outputs of the fetch/decode pipeline latch.
interface fd_latch_if #(
  parameter int PC_W   = 12,
  parameter int INSN_W = 32,
  parameter int CNT_W  = 16
);

  logic [PC_W-1:0]   pc_in;
  logic [INSN_W-1:0] insn_in;
  logic              valid_in;
  logic              stall;
  logic              flush;
  logic [PC_W-1:0]   pc_out;
  logic [INSN_W-1:0] insn_out;
  logic              valid_out;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output pc_in, insn_in, valid_in, stall, flush,
    input  pc_out, insn_out, valid_out, stall_cycles
  );

  modport slave (
    input  pc_in, insn_in, valid_in, stall, flush,
    output pc_out, insn_out, valid_out, stall_cycles
  );

endinterface

// File: rtl/fd_latch_reg_neg_n.sv
// Width-parameterised falling-edge register with enable and synchronous clear to zero.
module reg_neg_n #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q = '0;

  always_ff @(negedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fd_latch.sv
// Fetch/decode pipeline latch: priority clr > flush > stall > load, plus a saturating
// counter of edges spent stalled while holding a real instruction.
module fd_latch
  import fd_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INSN_W = INSN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          clr,
  fd_latch_if.slave     bus
);

  logic [PC_W-1:0]   w_pcD;
  logic [PC_W-1:0]   w_pcQ;
  logic [INSN_W-1:0] w_insnD;
  logic [INSN_W-1:0] w_insnQ;
  logic              w_validQ;
  logic              w_en;
  logic              w_clrEff;
  logic              w_cntInc;
  fd_state_t         w_state;
  fd_state_t         w_nextState;
  logic [CNT_W-1:0]  r_stallCycles = '0;

  assign w_state = fd_state_t'(w_validQ);

  // Any unknown bit in the stored state is treated like a clear so the latch self-heals.
  assign w_clrEff = clr | $isunknown({w_validQ, w_pcQ, w_insnQ, r_stallCycles});

  always_comb begin
    w_pcD       = bus.pc_in;
    w_insnD     = bus.insn_in;
    w_nextState = FULL;
    w_en        = 1'b1;
    if (bus.flush) begin
      w_pcD       = '0;
      w_insnD     = INSN_W'(NOP);
      w_nextState = EMPTY;
    end else if (bus.stall) begin
      w_en        = 1'b0;
      w_nextState = w_state;
    end else if (!bus.valid_in) begin
      w_insnD     = INSN_W'(NOP);
      w_nextState = EMPTY;
    end
  end

  reg_neg_n #(.W(PC_W)) u_pcReg (
    .clk (clk), .clr (w_clrEff), .en (w_en), .d (w_pcD), .q (w_pcQ)
  );

  reg_neg_n #(.W(INSN_W)) u_insnReg (
    .clk (clk), .clr (w_clrEff), .en (w_en), .d (w_insnD), .q (w_insnQ)
  );

  reg_neg_n #(.W(1)) u_validReg (
    .clk (clk), .clr (w_clrEff), .en (w_en), .d (logic'(w_nextState)), .q (w_validQ)
  );

  assign w_cntInc = !bus.flush && bus.stall && (w_state == FULL) && (r_stallCycles != '1);

  always_ff @(negedge clk) begin
    if (w_clrEff) begin
      r_stallCycles <= '0;
    end else if (w_cntInc) begin
      r_stallCycles <= r_stallCycles + 1'b1;
    end
  end

  assign bus.pc_out       = w_pcQ;
  assign bus.insn_out     = w_insnQ;
  assign bus.valid_out    = w_validQ;
  assign bus.stall_cycles = r_stallCycles;

endmodule

// File: doc/fd_latch.md
FD_LATCH -- requirements
Module: fd_latch

Interface
REQ-001 Parameter PC_W, default 12, program-counter width.
REQ-002 Parameter INSN_W, default 32, instruction width.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on the falling edge of clk.
REQ-005 clr  input  1  reset; synchronous and active-high, sampled on the falling edge of clk.
REQ-006 pc_in  input  PC_W  PC+1 value from the fetch stage.
REQ-007 insn_in  input  INSN_W  instruction word from instruction memory.
REQ-008 valid_in  input  1  fetch stage presents a real instruction.
REQ-009 stall  input  1  hazard unit holds the decode stage; latch keeps its contents.
REQ-010 flush  input  1  taken branch or jump; latch loads a bubble.
REQ-011 pc_out  output  PC_W  latched PC+1.
REQ-012 insn_out  output  INSN_W  latched instruction, or NOP when empty.
REQ-013 valid_out  output  1  latch holds a real instruction (state FULL).
REQ-014 stall_cycles  output  CNT_W  saturating count of stalled falling edges while FULL.

Function
REQ-015 Two states are defined: EMPTY (valid_out=0) and FULL (valid_out=1).
REQ-016 At each falling edge the block applies exactly one action, in priority order clr > flush > stall > load.
REQ-017 On flush: state becomes EMPTY; insn_out becomes NOP (all zeros); pc_out becomes 0; stall_cycles is unchanged.
REQ-018 On stall without flush: pc_out, insn_out and state hold; if state is FULL, stall_cycles increments by 1.
REQ-019 When stall_cycles equals all-ones, it holds at all-ones instead of wrapping.
REQ-020 On stall while EMPTY, stall_cycles does not change.
REQ-021 On load (no clr, flush or stall) with valid_in=1: pc_out is set to pc_in, insn_out to insn_in, and state becomes FULL.
REQ-022 On load with valid_in=0: state becomes EMPTY, insn_out becomes NOP, and pc_out is set to pc_in.
REQ-023 Latency from inputs to outputs is exactly one falling edge; outputs are driven directly from registers, with no combinational path from inputs to outputs.
REQ-024 flush and stall asserted together resolve as flush: the bubble is inserted and the held instruction is discarded.
REQ-025 If any state bit is X at a falling edge, the block loads the reset values.
REQ-026 When EMPTY, insn_out is always NOP, regardless of stall.

Reset
REQ-027 When clr=1 at a falling edge, all of the following are cleared: pc_out=0, insn_out=NOP, valid_out=0, stall_cycles=0.
REQ-028 clr asserted mid-stall or mid-flush overrides both; the next non-clr edge follows normal priority.
REQ-029 Simulation initial value of every register equals its reset value.

Structure
REQ-030 Shared package fd_pkg holds PC_W, INSN_W, CNT_W defaults and the NOP constant (all zeros).
REQ-031 The block instantiates one sub-module, reg_neg_n: a width-parameterised falling-edge register with enable and synchronous clear.
REQ-032 reg_neg_n is used for the pc, insn and valid fields.
REQ-033 The stall_cycles counter and the priority logic are written inline in fd_latch.

Verification
REQ-034 Reset: clr=1 for one falling edge with arbitrary inputs -> pc_out=0, insn_out=0, valid_out=0, stall_cycles=0.
REQ-035 Load: pc_in=12'h005, insn_in=32'h2842_0003, valid_in=1 -> after one falling edge, pc_out=005, insn_out=2842_0003, valid_out=1.
REQ-036 Stall hold: from FULL, stall=1 for 3 edges while inputs change -> outputs unchanged, stall_cycles=3; release -> new inputs load on the next edge.
REQ-037 Flush priority: stall=1 and flush=1 together while FULL -> valid_out=0, insn_out=0, pc_out=0, stall_cycles unchanged.
REQ-038 Saturation: preload stall_cycles to 16'hFFFE, stall 3 edges while FULL -> stall_cycles=16'hFFFF, held.
REQ-039 Bubble/EMPTY stall: valid_in=0 load, then stall=1 for 2 edges -> valid_out=0, insn_out=0, stall_cycles unchanged.
